// File: rtl/dvp_frame_tx_pkg.sv
// Shared types and helpers for the DVP frame transmitter: FSM encoding,
// byte order and line-length arithmetic.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  localparam bit BYTE_HI_FIRST = 1'b1;

  function automatic int line_cyc(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

endpackage

// File: rtl/dvp_frame_tx_if.sv
// Camera-side bundle: enable, pixel fetch handshake and the DVP byte stream.
interface dvp_frame_tx_if;
  logic        enable;
  logic        pix_req;
  logic [15:0] pix_data;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_start;
  logic        busy;

  modport master (
    input  enable, pix_data,
    output pix_req, dvp_vsync, dvp_href, dvp_data, frame_start, busy
  );

  modport slave (
    output enable, pix_data,
    input  pix_req, dvp_vsync, dvp_href, dvp_data, frame_start, busy
  );
endinterface

// File: rtl/dvp_line_timer.sv
// Horizontal timing: free-running line counter plus decoded byte and fetch
// windows. Windows are decoded one cycle ahead of the registered outputs.
module dvp_line_timer import dvp_pkg::*; #(
  parameter  int H_ACTIVE = 480,
  parameter  int H_BLANK  = 64,
  localparam int LINE_CYC = line_cyc(H_ACTIVE, H_BLANK),
  localparam int HW       = $clog2(LINE_CYC)
) (
  input  logic          video_clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic [HW-1:0] hcnt,
  output logic          line_end,
  output logic          href_win,
  output logic          req_win,
  output logic          pre_win
);

  assign line_end = (hcnt == HW'(LINE_CYC - 1));
  assign href_win = (hcnt < HW'(2 * H_ACTIVE));
  // Pixel k is fetched two cycles before its high byte; pixel 0 comes from
  // the prefetch slot at the tail of the previous line's blanking.
  assign req_win  = !hcnt[0] && (hcnt < HW'(2 * H_ACTIVE - 2));
  assign pre_win  = (hcnt == HW'(LINE_CYC - 2));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                 hcnt <= '0;
    else if (clear || line_end) hcnt <= '0;
    else                        hcnt <= hcnt + 1'b1;
  end

endmodule

// File: rtl/dvp_frame_tx.sv
// OV5640-style DVP source: frame FSM, pixel fetch and RGB565-to-byte
// serialisation with vsync/href qualifiers, all outputs registered.
module dvp_frame_tx import dvp_pkg::*; #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int H_BLANK     = 64,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 4
) (
  input logic            video_clk,
  input logic            rst_n,
  dvp_frame_tx_if.master bus
);

  localparam int LINE_CYC = line_cyc(H_ACTIVE, H_BLANK);
  localparam int HW       = $clog2(LINE_CYC);
  localparam int VW       = 16;

  state_t          state, state_nx;
  logic [VW-1:0]   vcnt, vcnt_nx;
  logic [HW-1:0]   hcnt;
  logic            line_end, href_win, req_win, pre_win;
  logic            last_line, next_active;
  logic            href_nx, req_nx, fs_nx;
  logic            req_d;
  logic [15:0]     pix_hold;
  logic [7:0]      byte_nx;
  int              n_lines;

  dvp_line_timer #(.H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK)) u_line_timer (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clear     (state == IDLE),
    .hcnt      (hcnt),
    .line_end  (line_end),
    .href_win  (href_win),
    .req_win   (req_win),
    .pre_win   (pre_win)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nx = state;
    vcnt_nx  = vcnt;
    unique case (state)
      VSYNC:   n_lines = VSYNC_LINES;
      VBACK:   n_lines = V_BACK;
      ACTIVE:  n_lines = V_ACTIVE;
      VFRONT:  n_lines = V_FRONT;
      default: n_lines = 1;
    endcase
    last_line = (vcnt == VW'(n_lines - 1));

    if (state == IDLE) begin
      if (bus.enable) begin
        state_nx = VSYNC;
        vcnt_nx  = '0;
      end
    end else if (line_end) begin
      if (!last_line) begin
        vcnt_nx = vcnt + 1'b1;
      end else begin
        vcnt_nx = '0;
        unique case (state)
          VSYNC:   state_nx = VBACK;
          VBACK:   state_nx = ACTIVE;
          ACTIVE:  state_nx = VFRONT;
          VFRONT:  state_nx = bus.enable ? VSYNC : IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // The line after this one carries pixels, so its first fetch goes out now.
  assign next_active = ((state == VBACK)  && (vcnt == VW'(V_BACK - 1))) ||
                       ((state == ACTIVE) && (vcnt != VW'(V_ACTIVE - 1)));

  assign href_nx = (state == ACTIVE) && href_win;
  assign req_nx  = ((state == ACTIVE) && req_win) || (pre_win && next_active);
  assign fs_nx   = (state == VSYNC) && (vcnt == '0) && (hcnt == '0);

  always_comb begin
    byte_nx = 8'h00;
    if (href_nx) begin
      if (req_d) byte_nx = BYTE_HI_FIRST ? bus.pix_data[15:8] : bus.pix_data[7:0];
      else       byte_nx = BYTE_HI_FIRST ? pix_hold[7:0]      : pix_hold[15:8];
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vcnt  <= '0;
    end else begin
      state <= state_nx;
      vcnt  <= vcnt_nx;
    end
  end

  // The first byte of a pixel bypasses pix_hold so it leaves two cycles
  // after the request; the second byte is taken from the held copy.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d           <= 1'b0;
      pix_hold        <= '0;
      bus.pix_req     <= 1'b0;
      bus.dvp_vsync   <= 1'b0;
      bus.dvp_href    <= 1'b0;
      bus.dvp_data    <= '0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      req_d           <= bus.pix_req;
      if (req_d) pix_hold <= bus.pix_data;
      bus.pix_req     <= req_nx;
      bus.dvp_vsync   <= (state == VSYNC);
      bus.dvp_href    <= href_nx;
      bus.dvp_data    <= byte_nx;
      bus.frame_start <= fs_nx;
      bus.busy        <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Scoreboard bench for dvp_frame_tx on a tiny 4x2 frame (12-cycle lines,
// 60-cycle frames): idle, single frame, back-to-back, early disable, reset.
module tb_dvp_frame_tx;

  localparam int FRAME_CYC = 60;
  localparam int LINE_BYTES = 8;

  logic        video_clk = 1'b0;
  logic        rst_n     = 1'b1;
  int unsigned cyc       = 0;
  int          n_cmp     = 0;
  int          n_bad     = 0;

  dvp_frame_tx_if bus ();

  dvp_frame_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 video_clk = ~video_clk;
  always @(posedge video_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.pix_req, bus.dvp_vsync, bus.dvp_href, bus.dvp_data, bus.frame_start, bus.busy};
  endfunction

  // Pixel source and scoreboard producer: answers each request one cycle
  // later and records the two bytes expected at t+2 and t+3.
  typedef struct { logic [7:0] b; int unsigned c; } exp_t;
  exp_t        sb[$];
  logic [15:0] next_pix = 16'hA5C3;
  logic        req_seen = 1'b0;
  int unsigned req_cyc  = 0;

  always @(negedge video_clk) begin
    if (!rst_n) begin
      sb.delete();
      req_seen     = 1'b0;
      bus.pix_data = '0;
    end else begin
      if (req_seen) begin
        bus.pix_data = next_pix;
        sb.push_back('{next_pix[15:8], req_cyc + 2});
        sb.push_back('{next_pix[7:0],  req_cyc + 3});
        next_pix = next_pix + 16'd1;
      end
      req_seen = bus.pix_req;
      req_cyc  = cyc;
    end
  end

  // Monitor: pops the scoreboard on every href byte and gathers statistics.
  int          n_vsync, n_href, n_req, n_fs, n_busy;
  int unsigned fs_cyc[$];
  int          runs[$];
  logic [7:0]  bytes_seen[$];
  int          run        = 0;
  logic        prev_vsync = 1'b0;
  exp_t        e;

  always @(negedge video_clk) begin
    if (!rst_n) begin
      run        = 0;
      prev_vsync = 1'b0;
    end else begin
      if (bus.dvp_href) begin
        bytes_seen.push_back(bus.dvp_data);
        run++;
        check("byte_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("byte_value", bus.dvp_data, e.b);
          check("byte_cycle", cyc, e.c);
        end
      end else begin
        check("blank_data_zero", bus.dvp_data, 0);
        if (run != 0) runs.push_back(run);
        run = 0;
      end
      check("href_vs_vsync", bus.dvp_href & bus.dvp_vsync, 0);
      if (bus.frame_start) begin
        check("fs_at_vsync_rise", {bus.dvp_vsync, prev_vsync}, 2'b10);
        fs_cyc.push_back(cyc);
        n_fs++;
      end
      n_vsync += int'(bus.dvp_vsync);
      n_href  += int'(bus.dvp_href);
      n_req   += int'(bus.pix_req);
      n_busy  += int'(bus.busy);
      prev_vsync = bus.dvp_vsync;
    end
  end

  task automatic clear_stats();
    n_vsync = 0; n_href = 0; n_req = 0; n_fs = 0; n_busy = 0;
    fs_cyc.delete(); runs.delete(); bytes_seen.delete();
  endtask

  task automatic tick();
    @(posedge video_clk);
    #2;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int i = 0;
    while (bus.busy !== lvl && i < limit) begin tick(); i++; end
    check(name, bus.busy, lvl);
  endtask

  task automatic wait_href(input int limit, input string name);
    int i = 0;
    while (bus.dvp_href !== 1'b1 && i < limit) begin tick(); i++; end
    check(name, bus.dvp_href, 1);
  endtask

  task automatic wait_fs(input int n, input int limit, input string name);
    int i = 0;
    while (fs_cyc.size() < n && i < limit) begin tick(); i++; end
    check(name, fs_cyc.size() >= n, 1);
  endtask

  task automatic check_runs(input int n_lines, input string name);
    check(name, runs.size(), n_lines);
    for (int i = 0; i < runs.size(); i++) check("href_run_length", runs[i], LINE_BYTES);
  endtask

  logic [7:0] exp_bytes [16] = '{8'hA5, 8'hC3, 8'hA5, 8'hC4, 8'hA5, 8'hC5, 8'hA5, 8'hC6,
                                 8'hA5, 8'hC7, 8'hA5, 8'hC8, 8'hA5, 8'hC9, 8'hA5, 8'hCA};

  initial begin
    bus.enable = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", outs(), 0);
    repeat (3) @(posedge video_clk);
    #2 rst_n = 1'b1;

    // Idle with enable low.
    clear_stats();
    repeat (1000) tick();
    check("idle_vsync", n_vsync, 0);
    check("idle_href",  n_href,  0);
    check("idle_req",   n_req,   0);
    check("idle_fs",    n_fs,    0);
    check("idle_busy",  n_busy,  0);

    // Single frame from a one-cycle enable pulse.
    clear_stats();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    wait_busy(1'b1, 5, "busy_rise");
    wait_busy(1'b0, 100, "busy_fall");
    check("frame_busy_cycles", n_busy,  FRAME_CYC);
    check("frame_vsync_cycles", n_vsync, 12);
    check("frame_fs_count",    n_fs,    1);
    check("frame_req_count",   n_req,   8);
    check("frame_href_cycles", n_href,  16);
    check_runs(2, "frame_lines");
    check("frame_byte_count", bytes_seen.size(), 16);
    for (int i = 0; i < 16 && i < bytes_seen.size(); i++)
      check("frame_byte_table", bytes_seen[i], exp_bytes[i]);
    check("sb_drained_1", sb.size(), 0);

    // Back-to-back frames, then enable dropped mid-ACTIVE of the third.
    clear_stats();
    bus.enable = 1'b1;
    wait_fs(3, 400, "three_frames_started");
    for (int i = 1; i < fs_cyc.size(); i++)
      check("frame_period", fs_cyc[i] - fs_cyc[i-1], FRAME_CYC);
    wait_href(80, "href_in_frame3");
    repeat (3) tick();
    bus.enable = 1'b0;
    wait_busy(1'b0, 200, "frames_drain");
    check("cont_fs_count",    n_fs,    3);
    check("cont_vsync_cycles", n_vsync, 36);
    check("cont_req_count",   n_req,   24);
    check("cont_href_cycles", n_href,  48);
    check_runs(6, "cont_lines");
    repeat (200) tick();
    check("no_restart_fs", n_fs, 3);
    check("no_restart_busy", bus.busy, 0);
    check("sb_drained_2", sb.size(), 0);

    // Reset asserted while href is high, then a clean frame afterwards.
    clear_stats();
    bus.enable = 1'b1;
    wait_href(100, "href_before_reset");
    tick();
    #1 rst_n = 1'b0;
    #1 check("reset_mid_href", outs(), 0);
    repeat (3) @(posedge video_clk);
    #2 rst_n = 1'b1;
    clear_stats();
    wait_fs(1, 20, "fs_after_reset");
    bus.enable = 1'b0;
    wait_busy(1'b0, 200, "frame_after_reset_done");
    check("rst_fs_count",    n_fs,    1);
    check("rst_vsync_cycles", n_vsync, 12);
    check("rst_req_count",   n_req,   8);
    check("rst_href_cycles", n_href,  16);
    check_runs(2, "rst_lines");
    check("sb_drained_3", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
